// File: rtl/traffic_sensor_conditioner_if.sv
// Bundle of detector inputs, counter clear and conditioned outputs shared
// between the sensor front end (slave) and whoever drives/observes it (master).
interface traffic_sensor_conditioner_if;
    logic       sa_raw;
    logic       sb_raw;
    logic       cnt_clr;
    logic       Ta;
    logic       Tb;
    logic       fault_a;
    logic       fault_b;
    logic [7:0] veh_cnt_a;
    logic [7:0] veh_cnt_b;

    modport master (
        output sa_raw, sb_raw, cnt_clr,
        input  Ta, Tb, fault_a, fault_b, veh_cnt_a, veh_cnt_b
    );

    modport slave (
        input  sa_raw, sb_raw, cnt_clr,
        output Ta, Tb, fault_a, fault_b, veh_cnt_a, veh_cnt_b
    );
endinterface

// File: rtl/traffic_sensor_conditioner.sv
// Per-street loop-detector conditioning: sync, debounce, gap hold, stuck masking.
// Define SENSOR_COUNT_EN to build the saturating per-street vehicle counters.
module traffic_sensor_conditioner #(
    parameter int DEB_CYCLES   = 4,
    parameter int HOLD_CYCLES  = 6,
    parameter int STUCK_CYCLES = 1000,
    parameter int CNT_W        = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    traffic_sensor_conditioner_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        QUAL    = 2'd1,
        PRESENT = 2'd2,
        GAP     = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] L_DEB_M1   = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] L_HOLD_M1  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] L_STUCK    = CNT_W'(STUCK_CYCLES);
    localparam logic [CNT_W-1:0] L_STUCK_M1 = CNT_W'(STUCK_CYCLES - 1);

    logic [1:0] w_raw;
    logic [1:0] w_t;
    logic [1:0] w_fault;
    logic [7:0] w_cnt [2];

    assign w_raw = {bus.sb_raw, bus.sa_raw};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_chan
            logic             r_sync1;
            logic             r_s;
            state_t           r_state;
            logic [CNT_W-1:0] r_tmr;
            logic [CNT_W-1:0] r_stuck;
            logic             r_t;
            logic             r_fault;
            logic             w_occupied;
            logic             w_fault_hit;
            logic             w_fault_now;
            logic             w_enter;

            assign w_occupied  = (r_state == PRESENT) || (r_state == GAP);
            assign w_fault_hit = w_occupied && (r_stuck == L_STUCK_M1);
            // T is masked on the very edge the fault sets, not one cycle later.
            assign w_fault_now = r_fault || w_fault_hit;
            assign w_enter     = r_s && (((r_state == IDLE) && (DEB_CYCLES == 1)) ||
                                         ((r_state == QUAL) && (r_tmr == L_DEB_M1)));

            always_ff @(posedge clk) begin
                if (!reset) begin
                    r_sync1 <= 1'b0;
                    r_s     <= 1'b0;
                    r_state <= IDLE;
                    r_tmr   <= '0;
                    r_stuck <= '0;
                    r_t     <= 1'b0;
                    r_fault <= 1'b0;
                end else begin
                    r_sync1 <= w_raw[gi];
                    r_s     <= r_sync1;

                    if (!w_occupied) begin
                        r_stuck <= '0;
                    end else if (r_stuck != L_STUCK) begin
                        r_stuck <= r_stuck + CNT_W'(1);
                    end
                    if (w_fault_hit) begin
                        r_fault <= 1'b1;
                    end

                    case (r_state)
                        IDLE: begin
                            r_t <= 1'b0;
                            if (r_s) begin
                                if (DEB_CYCLES == 1) begin
                                    r_state <= PRESENT;
                                    r_t     <= ~w_fault_now;
                                end else begin
                                    r_state <= QUAL;
                                    r_tmr   <= CNT_W'(1);
                                end
                            end
                        end
                        QUAL: begin
                            r_t <= 1'b0;
                            if (!r_s) begin
                                r_state <= IDLE;
                                r_tmr   <= '0;
                            end else if (r_tmr == L_DEB_M1) begin
                                r_state <= PRESENT;
                                r_t     <= ~w_fault_now;
                            end else begin
                                r_tmr <= r_tmr + CNT_W'(1);
                            end
                        end
                        PRESENT: begin
                            r_t <= ~w_fault_now;
                            if (!r_s) begin
                                if (HOLD_CYCLES == 1) begin
                                    r_state <= IDLE;
                                    r_t     <= 1'b0;
                                end else begin
                                    r_state <= GAP;
                                    r_tmr   <= CNT_W'(1);
                                end
                            end
                        end
                        GAP: begin
                            r_t <= ~w_fault_now;
                            if (r_s) begin
                                r_state <= PRESENT;
                            end else if (r_tmr == L_HOLD_M1) begin
                                r_state <= IDLE;
                                r_t     <= 1'b0;
                            end else begin
                                r_tmr <= r_tmr + CNT_W'(1);
                            end
                        end
                        default: begin
                            r_state <= IDLE;
                            r_t     <= 1'b0;
                        end
                    endcase
                end
            end

            assign w_t[gi]     = r_t;
            assign w_fault[gi] = r_fault;

`ifdef SENSOR_COUNT_EN
            logic [7:0] r_cnt;

            // Clear wins over a same-cycle arrival; GAP re-triggers never count.
            always_ff @(posedge clk) begin
                if (!reset) begin
                    r_cnt <= 8'd0;
                end else if (bus.cnt_clr) begin
                    r_cnt <= 8'd0;
                end else if (w_enter && (r_cnt != 8'hFF)) begin
                    r_cnt <= r_cnt + 8'd1;
                end
            end

            assign w_cnt[gi] = r_cnt;
`else
            logic w_unused_enter;
            assign w_unused_enter = w_enter;
            assign w_cnt[gi]      = 8'd0;
`endif
        end
    endgenerate

`ifndef SENSOR_COUNT_EN
    logic w_unused_cnt_clr;
    assign w_unused_cnt_clr = bus.cnt_clr;
`endif

    assign bus.Ta        = w_t[0];
    assign bus.Tb        = w_t[1];
    assign bus.fault_a   = w_fault[0];
    assign bus.fault_b   = w_fault[1];
    assign bus.veh_cnt_a = w_cnt[0];
    assign bus.veh_cnt_b = w_cnt[1];

endmodule

// File: tb/tb_traffic_sensor_conditioner.sv
// Directed bench for traffic_sensor_conditioner: default-parameter instance plus
// a STUCK_CYCLES=20 instance for the stuck-detector scenario.
module tb_traffic_sensor_conditioner;

    logic clk;
    logic reset;
    int   passed;
    int   total;
    int   count_en;
    logic [7:0] exp_cnt_a;
    logic [7:0] exp_cnt_b;

    traffic_sensor_conditioner_if bus ();
    traffic_sensor_conditioner_if bus_s ();

    traffic_sensor_conditioner dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    traffic_sensor_conditioner #(.STUCK_CYCLES(20)) dut_s (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_s.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.sa_raw = 1'b1;   bus.sb_raw = 1'b1;   bus.cnt_clr = 1'b0;
        bus_s.sa_raw = 1'b1; bus_s.sb_raw = 1'b1; bus_s.cnt_clr = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        total++; if ({bus.Ta, bus.Tb} !== 2'b00) $display("FAIL reset_T: Ta,Tb=%b expected 00", {bus.Ta, bus.Tb}); else passed++;
        total++; if ({bus.fault_a, bus.fault_b} !== 2'b00) $display("FAIL reset_fault: faults=%b expected 00", {bus.fault_a, bus.fault_b}); else passed++;
        total++; if ({bus.veh_cnt_a, bus.veh_cnt_b} !== 16'd0) $display("FAIL reset_cnt: cnts=%h expected 0000", {bus.veh_cnt_a, bus.veh_cnt_b}); else passed++;
        total++; if ({bus_s.Ta, bus_s.Tb, bus_s.fault_a, bus_s.fault_b} !== 4'b0000) $display("FAIL reset_stuck_dut: T/fault=%b expected 0000", {bus_s.Ta, bus_s.Tb, bus_s.fault_a, bus_s.fault_b}); else passed++;
        bus.sa_raw = 1'b0;   bus.sb_raw = 1'b0;
        bus_s.sa_raw = 1'b0; bus_s.sb_raw = 1'b0;
        tick();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        $display("test_reset done");
    endtask

    // Raw rises before edge n; Ta must stay 0 through n+4 and be 1 after n+5.
    task automatic test_arrival();
        bus.sa_raw = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++; if (bus.Ta !== 1'b0) $display("FAIL arrival_early edge n+%0d: Ta=%b expected 0", i, bus.Ta); else passed++;
        end
        tick();
        if (count_en != 0) exp_cnt_a = exp_cnt_a + 8'd1;
        total++; if (bus.Ta !== 1'b1) $display("FAIL arrival_on_time: Ta=%b expected 1", bus.Ta); else passed++;
        total++; if (bus.veh_cnt_a !== exp_cnt_a) $display("FAIL arrival_cnt: veh_cnt_a=%0d expected %0d", bus.veh_cnt_a, exp_cnt_a); else passed++;
        $display("test_arrival done");
    endtask

    task automatic test_glitch();
        logic saw_tb;
        saw_tb = 1'b0;
        bus.sb_raw = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            saw_tb = saw_tb | bus.Tb;
        end
        bus.sb_raw = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            saw_tb = saw_tb | bus.Tb;
        end
        total++; if (saw_tb !== 1'b0) $display("FAIL glitch_T: Tb went %b expected 0", saw_tb); else passed++;
        total++; if (bus.veh_cnt_b !== exp_cnt_b) $display("FAIL glitch_cnt: veh_cnt_b=%0d expected %0d", bus.veh_cnt_b, exp_cnt_b); else passed++;
        $display("test_glitch done");
    endtask

    // Ta is already 1 with sa_raw high.
    task automatic test_gap();
        logic dropped;
        dropped = 1'b0;
        bus.sa_raw = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            dropped = dropped | ~bus.Ta;
        end
        bus.sa_raw = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            dropped = dropped | ~bus.Ta;
        end
        total++; if (dropped !== 1'b0) $display("FAIL gap_bridge: Ta dropped=%b expected 0", dropped); else passed++;
        total++; if (bus.veh_cnt_a !== exp_cnt_a) $display("FAIL gap_cnt: veh_cnt_a=%0d expected %0d", bus.veh_cnt_a, exp_cnt_a); else passed++;
        bus.sa_raw = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
            total++; if (bus.Ta !== 1'b1) $display("FAIL depart_early edge m+%0d: Ta=%b expected 1", i, bus.Ta); else passed++;
        end
        tick();
        total++; if (bus.Ta !== 1'b0) $display("FAIL depart_on_time: Ta=%b expected 0", bus.Ta); else passed++;
        for (int i = 0; i < 3; i++) tick();
        $display("test_gap done");
    endtask

    task automatic test_simultaneous();
        bus.sa_raw = 1'b1;
        bus.sb_raw = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        total++; if ({bus.Ta, bus.Tb} !== 2'b00) $display("FAIL simul_early: Ta,Tb=%b expected 00", {bus.Ta, bus.Tb}); else passed++;
        tick();
        if (count_en != 0) begin
            exp_cnt_a = exp_cnt_a + 8'd1;
            exp_cnt_b = exp_cnt_b + 8'd1;
        end
        total++; if ({bus.Ta, bus.Tb} !== 2'b11) $display("FAIL simul_arrive: Ta,Tb=%b expected 11", {bus.Ta, bus.Tb}); else passed++;
        total++; if ({bus.veh_cnt_a, bus.veh_cnt_b} !== {exp_cnt_a, exp_cnt_b}) $display("FAIL simul_cnt: cnts=%h expected %h", {bus.veh_cnt_a, bus.veh_cnt_b}, {exp_cnt_a, exp_cnt_b}); else passed++;
        bus.sa_raw = 1'b0;
        bus.sb_raw = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        total++; if ({bus.Ta, bus.Tb} !== 2'b11) $display("FAIL simul_hold: Ta,Tb=%b expected 11", {bus.Ta, bus.Tb}); else passed++;
        tick();
        total++; if ({bus.Ta, bus.Tb} !== 2'b00) $display("FAIL simul_depart: Ta,Tb=%b expected 00", {bus.Ta, bus.Tb}); else passed++;
        for (int i = 0; i < 3; i++) tick();
        $display("test_simultaneous done");
    endtask

    task automatic test_stuck();
        int waited;
        waited = 0;
        bus_s.sb_raw = 1'b1;
        while (bus_s.Tb !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        total++; if (waited !== 6) $display("FAIL stuck_rise: Tb rose after %0d edges expected 6", waited); else passed++;
        for (int i = 0; i < 19; i++) tick();
        total++; if ({bus_s.Tb, bus_s.fault_b} !== 2'b10) $display("FAIL stuck_before: Tb,fault_b=%b expected 10", {bus_s.Tb, bus_s.fault_b}); else passed++;
        tick();
        total++; if ({bus_s.Tb, bus_s.fault_b} !== 2'b01) $display("FAIL stuck_hit: Tb,fault_b=%b expected 01", {bus_s.Tb, bus_s.fault_b}); else passed++;
        bus_s.sb_raw = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        total++; if ({bus_s.Tb, bus_s.fault_b, bus_s.fault_a} !== 3'b010) $display("FAIL stuck_sticky: Tb,fault_b,fault_a=%b expected 010", {bus_s.Tb, bus_s.fault_b, bus_s.fault_a}); else passed++;
        reset = 1'b0;
        tick();
        total++; if (bus_s.fault_b !== 1'b0) $display("FAIL stuck_reset: fault_b=%b expected 0", bus_s.fault_b); else passed++;
        reset = 1'b1;
        exp_cnt_a = 8'd0;
        exp_cnt_b = 8'd0;
        for (int i = 0; i < 3; i++) tick();
        $display("test_stuck done");
    endtask

    task automatic test_counter();
        for (int k = 0; k < 300; k++) begin
            bus.sa_raw = 1'b1;
            for (int i = 0; i < 7; i++) tick();
            bus.sa_raw = 1'b0;
            for (int i = 0; i < 9; i++) tick();
            if (count_en != 0 && exp_cnt_a != 8'hFF) exp_cnt_a = exp_cnt_a + 8'd1;
        end
        total++; if (bus.veh_cnt_a !== exp_cnt_a) $display("FAIL cnt_saturate: veh_cnt_a=%0d expected %0d", bus.veh_cnt_a, exp_cnt_a); else passed++;
        bus.sa_raw = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        bus.cnt_clr = 1'b1;
        tick();
        bus.cnt_clr = 1'b0;
        total++; if ({bus.Ta, bus.veh_cnt_a} !== {1'b1, 8'd0}) $display("FAIL cnt_clr_priority: Ta=%b veh_cnt_a=%0d expected Ta=1 cnt=0", bus.Ta, bus.veh_cnt_a); else passed++;
        tick();
        total++; if (bus.veh_cnt_a !== 8'd0) $display("FAIL cnt_clr_hold: veh_cnt_a=%0d expected 0", bus.veh_cnt_a); else passed++;
        bus.sa_raw = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        $display("test_counter done");
    endtask

    initial begin
        passed = 0;
        total  = 0;
`ifdef SENSOR_COUNT_EN
        count_en = 1;
`else
        count_en = 0;
`endif
        exp_cnt_a = 8'd0;
        exp_cnt_b = 8'd0;
        test_reset();
        test_arrival();
        test_glitch();
        test_gap();
        test_simultaneous();
        test_stuck();
        test_counter();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/traffic_sensor_conditioner.md
# traffic_sensor_conditioner

Front-end stage that turns the two raw vehicle-loop detector inputs into the clean `Ta`/`Tb` traffic-present signals consumed by the `traffic_lights` controller. It does four things per street:
- synchronises the raw input;
- debounces arrivals;
- extends departures by a hold (gap) time so the controller does not drop green between closely spaced cars;
- flags a detector stuck high and masks it.

Optionally it also counts vehicles per street for maintenance readout.

## Interface
Parameters:
- `DEB_CYCLES`, 4: consecutive high samples required to declare a vehicle present (≥1).
- `HOLD_CYCLES`, 6: consecutive low samples required to declare the street empty (≥1).
- `STUCK_CYCLES`, 1000: continuous presence longer than this marks the detector faulty (≥2).
- `CNT_W`, 16: width of the internal timers. Must hold `STUCK_CYCLES`.

Ports:
- `clk`, input, 1: single clock. All logic on its rising edge.
- `reset`, input, 1: synchronous, active-low. Sampled on `clk` rising edge.
- `sa_raw`, input, 1: street A loop detector, asynchronous.
- `sb_raw`, input, 1: street B loop detector, asynchronous.
- `cnt_clr`, input, 1: synchronous clear of the vehicle counters.
- `Ta`, output, 1: conditioned traffic present on street A (registered).
- `Tb`, output, 1: conditioned traffic present on street B (registered).
- `fault_a`, output, 1: street A detector stuck-high flag (sticky).
- `fault_b`, output, 1: street B detector stuck-high flag (sticky).
- `veh_cnt_a`, output, 8: street A vehicle count.
- `veh_cnt_b`, output, 8: street B vehicle count.

## Operation
- Each raw input passes through a 2-flop synchroniser. The second flop output is `s`.
- Two identical, independent channel FSMs, one per street. Each has one `CNT_W` timer and one stuck timer.

Channel FSM states. Every decision is made on a sample of `s`.
- `IDLE`: T=0.
  - s=1: if `DEB_CYCLES`==1 go to `PRESENT`, else go to `QUAL` with tmr=1.
- `QUAL`: T=0.
  - s=0: go to `IDLE`, tmr=0.
  - s=1: if tmr==`DEB_CYCLES`-1 go to `PRESENT`, else tmr++.
- `PRESENT`: T=1.
  - s=0: if `HOLD_CYCLES`==1 go to `IDLE`, else go to `GAP` with tmr=1.
- `GAP`: T=1.
  - s=1: go to `PRESENT`. Re-trigger needs no debounce.
  - s=0: if tmr==`HOLD_CYCLES`-1 go to `IDLE`, else tmr++.

Stuck detection and masking:
- The stuck timer counts cycles spent in `PRESENT`/`GAP` and clears in `IDLE`/`QUAL`.
- When it reaches `STUCK_CYCLES`, `fault_x` sets. It stays set until `reset`.
- While `fault_x`=1, `Tx` is forced to 0 so the other street is never starved. The FSM keeps running.

Reset values and reset behaviour:
- `reset`=0 on an edge clears all state: FSMs to `IDLE`, timers 0, synchroniser flops 0, `Ta`=`Tb`=0, faults 0, counts 0.
- A reset mid-operation is honoured immediately, whatever the FSM state.

## Timing
- Arrival latency: raw held high from before edge n → T=1 after edge n+1+`DEB_CYCLES` (2 synchroniser cycles, then `DEB_CYCLES` samples).
- Departure latency: raw low from before edge n, with no re-trigger → T=0 after edge n+1+`HOLD_CYCLES`.
- A high pulse shorter than `DEB_CYCLES` samples produces no T activity.
- A low gap shorter than `HOLD_CYCLES` samples keeps T continuously 1.
- Fault: `fault_x` rises on the edge where the stuck count reaches `STUCK_CYCLES`. `Tx` drops to 0 on that same edge.
- Channels A and B are fully independent. Simultaneous events on both are processed in the same cycle.

## Configuration
- `SENSOR_COUNT_EN` defined:
  - Each channel has an 8-bit vehicle counter.
  - The counter increments on every transition into `PRESENT` from `IDLE` or `QUAL`. A `GAP`→`PRESENT` re-trigger is not counted.
  - It saturates at 255 and does not wrap.
  - `cnt_clr`=1 zeroes both counters on the next edge, with priority over a same-cycle increment.
- `SENSOR_COUNT_EN` undefined: `veh_cnt_a`/`veh_cnt_b` are tied to 0, `cnt_clr` is ignored, and no counter flops are built.

## Test plan
All scenarios use default parameters.
- Reset check: hold `reset`=0 for 3 cycles with raw inputs high → `Ta`=`Tb`=0, faults 0, counts 0.
- Clean arrival: `sa_raw` rises before edge n and stays high → `Ta`=1 after edge n+5, not earlier.
- Glitch rejection: `sb_raw` high for exactly 3 cycles, then low → `Tb` stays 0. With `SENSOR_COUNT_EN` defined, `veh_cnt_b` stays 0.
- Gap bridging: `Ta`=1, then `sa_raw` low for 4 cycles, then high → `Ta` stays 1 and `veh_cnt_a` is unchanged. Then `sa_raw` falls before edge m and stays low → `Ta`=0 after edge m+7.
- Stuck detector: `STUCK_CYCLES`=20, `sb_raw` held high → `fault_b`=1 and `Tb`=0 on the 20th cycle after `Tb` rose. Both remain until `reset`=0.
- Counter (with `SENSOR_COUNT_EN`): 300 debounced arrivals on A → `veh_cnt_a`=255. Then `cnt_clr`=1 in the same cycle as a qualifying arrival → `veh_cnt_a`=0.
